// File: rtl/motoro3_line_calc_param_seq_pkg.sv
// Shared types and constants for the motor line calculator.
// Holds the FSM encoding, mode codes and the sine amplitude table.
package motoro3_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULP,
        S_CLAMP,
        S_SINE,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_NORM  = 2'd0;
    localparam logic [1:0] MODE_BRAKE = 2'd1;
    localparam logic [1:0] MODE_FULL  = 2'd2;
    localparam logic [1:0] MODE_NORM3 = 2'd3;

    localparam logic [1:0] SPLIT_4 = 2'd0;
    localparam logic [1:0] SPLIT_8 = 2'd1;

    // Steps from here on lie in the negative half-wave.
    localparam logic [3:0] DIR_FIRST = 4'd9;

    // round(255*|sin(2*pi*k/16)|), entry k at bits [8k+7:8k].
    localparam logic [127:0] SINE_TAB = {
        8'd98, 8'd180, 8'd236, 8'd255,
        8'd236, 8'd180, 8'd98, 8'd0,
        8'd98, 8'd180, 8'd236, 8'd255,
        8'd236, 8'd180, 8'd98, 8'd0
    };

    function automatic logic [7:0] sine_amp(input logic [3:0] k);
        return SINE_TAB[{k, 3'b000} +: 8];
    endfunction

    // Coarser step resolutions snap the index down to the grid.
    function automatic logic [3:0] eff_step(
        input logic [3:0] s,
        input logic [1:0] split
    );
        logic [3:0] r;
        unique case (split)
            SPLIT_4: r = {s[3:2], 2'b00};
            SPLIT_8: r = {s[3:1], 1'b0};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/motoro3_line_calc_param_seq_if.sv
// Request/response bundle of the line calculator.
// The requester is the master, the calculator is the slave.
interface motoro3_line_calc_param_seq_if #(
    parameter int NCH = 3,
    parameter int LW  = 12
);
    import motoro3_pkg::*;

    localparam int PW = LW + 1;

    logic              start;
    logic [1:0]        m3LpwmStep;
    logic [7:0]        m3r_power_percent;
    logic [LW-1:0]     m3r_pwmLenWant;
    logic [LW-1:0]     m3r_pwmMinMask;
    logic [1:0]        m3r_stepSplitMax;
    logic [4*NCH-1:0]  lcStep;
    logic              busy;
    logic              done;
    logic [PW-1:0]     plLen;
    logic [PW*NCH-1:0] slLen;
    logic [NCH-1:0]    slDir;

    modport master (
        output start, m3LpwmStep, m3r_power_percent,
        output m3r_pwmLenWant, m3r_pwmMinMask,
        output m3r_stepSplitMax, lcStep,
        input  busy, done, plLen, slLen, slDir
    );

    modport slave (
        input  start, m3LpwmStep, m3r_power_percent,
        input  m3r_pwmLenWant, m3r_pwmMinMask,
        input  m3r_stepSplitMax, lcStep,
        output busy, done, plLen, slLen, slDir
    );

endinterface

// File: rtl/motoro3_line_calc_param_seq_sine.sv
// Combinational sine amplitude lookup.
// Maps a 4-bit step index to an 8-bit amplitude.
module motoro3_sine_len_rom
    import motoro3_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] amp
);

    // Pure table read; no state.
    assign amp = sine_amp(idx);

endmodule

// File: rtl/motoro3_line_calc_param_seq.sv
// Sequential power/sine length calculator for NCH motor lines.
// One shift-add multiplier serves both power scaling and sine scaling.
module motoro3_line_calc_param_seq
    import motoro3_pkg::*;
#(
    parameter int NCH = 3,
    parameter int LW  = 12
) (
    input logic clk,
    input logic nRst,
    motoro3_line_calc_param_seq_if.slave bus
);

    localparam int PW  = LW + 1;
    localparam int AW  = PW + 8;
    localparam int LNW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [LNW-1:0] LAST = LNW'(NCH - 1);

    state_t            st;
    logic [2:0]        cnt;
    logic [LNW-1:0]    line;
    logic [AW-1:0]     acc;

    logic [1:0]        mode_q;
    logic [1:0]        split_q;
    logic [7:0]        pwr_q;
    logic [LW-1:0]     want_q;
    logic [LW-1:0]     mask_q;
    logic [4*NCH-1:0]  step_q;

    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     pl_q;
    logic [PW*NCH-1:0] sl_q;
    logic [NCH-1:0]    dir_q;

    logic [3:0]        k;
    logic [7:0]        amp;
    logic [PW-1:0]     mcand;
    logic [7:0]        mplier;
    logic [AW-1:0]     addend;
    logic [PW-1:0]     p_raw;
    logic [PW-1:0]     pl_mode;
    logic [PW-1:0]     pl_cl;
    logic [PW-1:0]     s_raw;
    logic [PW-1:0]     sl_cl;

    assign k = eff_step(step_q[{line, 2'b00} +: 4], split_q);

    motoro3_sine_len_rom u_rom (
        .idx (k),
        .amp (amp)
    );

    // Shared multiplier operands: power during MULP, sine otherwise.
    always_comb begin
        mcand  = (st == S_MULP) ? {1'b0, want_q} : pl_q;
        mplier = (st == S_MULP) ? pwr_q : amp;
        addend = mplier[cnt] ? (AW'(mcand) << cnt) : '0;
    end

    // Power result: scale, apply mode, then drop below-minimum lengths.
    always_comb begin
        p_raw = acc[7 +: PW];
        unique case (mode_q)
            MODE_BRAKE: pl_mode = '0;
            MODE_FULL:  pl_mode = {1'b0, want_q};
            MODE_NORM,
            MODE_NORM3: pl_mode = p_raw;
        endcase
        pl_cl = (pl_mode < PW'(mask_q)) ? '0 : pl_mode;
    end

    // Sine result for the current line with the same minimum rule.
    always_comb begin
        s_raw = acc[8 +: PW];
        sl_cl = (s_raw < PW'(mask_q)) ? '0 : s_raw;
    end

    // Sequencer plus all registered outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            st      <= S_IDLE;
            cnt     <= '0;
            line    <= '0;
            acc     <= '0;
            mode_q  <= '0;
            split_q <= '0;
            pwr_q   <= '0;
            want_q  <= '0;
            mask_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pl_q    <= '0;
            sl_q    <= '0;
            dir_q   <= '0;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (bus.start) begin
                        st     <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    mode_q  <= bus.m3LpwmStep;
                    split_q <= bus.m3r_stepSplitMax;
                    pwr_q   <= bus.m3r_power_percent;
                    want_q  <= bus.m3r_pwmLenWant;
                    mask_q  <= bus.m3r_pwmMinMask;
                    step_q  <= bus.lcStep;
                    acc     <= '0;
                    cnt     <= '0;
                    st      <= S_MULP;
                end
                S_MULP: begin
                    acc <= acc + addend;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        st <= S_CLAMP;
                    end
                end
                S_CLAMP: begin
                    pl_q <= pl_cl;
                    acc  <= '0;
                    cnt  <= '0;
                    line <= '0;
                    st   <= S_SINE;
                end
                S_SINE: begin
                    acc <= acc + addend;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        st <= S_WR;
                    end
                end
                S_WR: begin
                    sl_q[int'(line)*PW +: PW] <= sl_cl;
                    dir_q[line] <= (k >= DIR_FIRST);
                    acc <= '0;
                    cnt <= '0;
                    if (line == LAST) begin
                        st     <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        line <= line + LNW'(1);
                        st   <= S_SINE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    st     <= S_IDLE;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.plLen = pl_q;
    assign bus.slLen = sl_q;
    assign bus.slDir = dir_q;

endmodule

// File: doc/motoro3_line_calc_param_seq.md
MOTORO3_LINE_CALC_PARAM_SEQ -- requirements
Module: motoro3_line_calc_param_seq

Interface
REQ-001 Parameter NCH, default 3, number of motor lines computed per request.
REQ-002 Parameter LW, default 12, width of m3r_pwmLenWant and m3r_pwmMinMask; PW = LW+1 is the length output width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 nRst  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle request; accepted only in IDLE.
REQ-006 m3LpwmStep  in  2  mode: 0/3 normal, 1 brake (all lengths 0), 2 full (plLen = m3r_pwmLenWant, power ignored).
REQ-007 m3r_power_percent  in  8  power in 1/128 units (128 = 100%, 255 ~ 199%).
REQ-008 m3r_pwmLenWant  in  LW  nominal PWM length; m3r_pwmMinMask  in  LW  minimum non-zero length.
REQ-009 m3r_stepSplitMax  in  2  step resolution: 0 = 4 steps, 1 = 8 steps, 2/3 = 16 steps.
REQ-010 lcStep  in  4*NCH  per-line step index, line i at bits [4i+3:4i].
REQ-011 busy  out  1  high from accepted start until done.
REQ-012 done  out  1  one-cycle pulse, outputs valid and stable from this cycle.
REQ-013 plLen  out  PW  scaled power length; slLen  out  PW*NCH  per-line sine length; slDir  out  NCH  per-line half-wave sign.

Function
REQ-014 FSM states IDLE, LOAD, MULP, CLAMP, SINE, WR, DONE; IDLE->LOAD on start, LOAD->MULP, MULP->CLAMP after 8 cycles, CLAMP->SINE, SINE->WR after 8 cycles, WR->SINE for next line else DONE, DONE->IDLE.
REQ-015 LOAD snapshots all inputs; input changes after LOAD do not affect the current computation.
REQ-016 MULP computes P = (m3r_pwmLenWant * m3r_power_percent) >> 7 with an 8-cycle shift-add, truncating; P fits PW bits, no saturation.
REQ-017 CLAMP applies mode: brake -> 0, full -> m3r_pwmLenWant; then if result < m3r_pwmMinMask, result = 0; result registered as plLen.
REQ-018 Effective step: split 0 clears lcStep bits [1:0], split 1 clears bit [0], split 2/3 unchanged.
REQ-019 SINE computes slLen_i = (plLen * S[k]) >> 8 over 8 cycles, truncating, S = round(255*|sin(2*pi*k/16)|), e.g. S0=0, S1=98, S2=180, S3=236, S4=255, symmetric.
REQ-020 slLen_i < m3r_pwmMinMask forces slLen_i = 0; slDir_i = 1 for k in 9..15, else 0.
REQ-021 WR writes line i outputs; lines processed in order 0..NCH-1.
REQ-022 Latency start-to-done = 11 + 9*NCH cycles (38 for NCH=3); busy high exactly those cycles minus the done cycle... busy deasserts in the cycle done is high.
REQ-023 start while busy is ignored, not queued; start in the done cycle is ignored.
REQ-024 Outputs hold last values between requests; partially written outputs are never visible before done except already-written lines.

Reset
REQ-025 nRst low: FSM IDLE, busy 0, done 0, plLen 0, slLen all 0, slDir all 0, counters 0, asynchronously.
REQ-026 Reset mid-operation aborts; no done pulse issued for the aborted request.

Structure
REQ-027 Sine table constants, mode encodings and state encoding reside in shared package motoro3_pkg.
REQ-028 Sine lookup is sub-module motoro3_sine_len_rom (4-bit index in, 8-bit amplitude out, combinational); multiply datapath is shared between MULP and SINE.

Verification
REQ-029 LenWant=1000, power=128, mode 0, split 2, steps {0,4,2}, mask 0 -> plLen=1000, slLen={0,996,703}, done at cycle 38.
REQ-030 LenWant=1000, power=255, step 3 on line 0 -> plLen=1992, slLen0=1836; steps {12,9,0} -> slDir=3'b011.
REQ-031 LenWant=1000, power=10, mask=100 -> plLen=0, all slLen 0; mode 1 any power -> all 0; mode 2 power=5 -> plLen=1000.
REQ-032 split 0 with steps {3,6,1} -> lines use k={0,4,0} -> slLen={0,996,0} at power 128.
REQ-033 start pulsed again at cycle 5 and in done cycle -> ignored, single done; nRst low at cycle 20 -> all outputs 0, no done, next start completes normally in 38 cycles.
